bluetooth_rx: RTL and testbench

UART receiver for the Bluetooth module link. It is the receive-side counterpart of the existing transmitter.
- It oversamples the serial line using an external strobe at OVERSAMPLE× the baud rate (115200 baud).
- It deframes start, 8 data bits (LSB first), even parity and stop.
- It presents each received byte with a one-cycle valid pulse and error flags to the packet/command logic downstream.

---
 rtl/bluetooth_rx.sv | 213 +++++++++++++++++++++
 tb/tb_bluetooth_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_rx.sv
// UART receiver for the Bluetooth module link: oversampled 8E1 deframer with
// 2-of-3 mid-bit majority voting, one-clk valid pulse and held error flags.
`timescale 1ns/1ps
module bluetooth_rx #(
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       rx,
    input  logic       sample_tick,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_ZERO = TW'(0);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic even_parity_bit(input logic [7:0] d);
        return ^d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   prev_q;
    state_t                 state_q, state_d;
    logic [TW-1:0]          t_q, t_d, t_inc_s;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic                   maj_s;
    logic [7:0]             data_q, data_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign maj_s   = maj3(s0_q, s1_q, rx_s);
    assign t_inc_s = t_q + T_ONE;

    // Input synchronizer and tick-sampled previous line value for edge detection
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= {SYNC_STAGES{1'b1}};
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (sample_tick) begin
                prev_q <= rx_s;
            end else begin
                prev_q <= prev_q;
            end
        end
    end

    // Deframing state register and registered outputs
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            t_q     <= T_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            data_q  <= 8'h00;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state logic: everything advances only on sample ticks, valid self-clears
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;

        if (sample_tick) begin
            if (t_q == T_S0) begin
                s0_d = rx_s;
            end else if (t_q == T_S1) begin
                s1_d = rx_s;
            end else begin
                s0_d = s0_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // The detecting tick is tick 0 of the start bit
                    if (prev_q && !rx_s) begin
                        state_d = ST_START;
                        t_d     = T_ONE;
                    end else begin
                        t_d = T_ZERO;
                    end
                end
                ST_START: begin
                    if ((t_q == T_DEC) && maj_s) begin
                        state_d = ST_IDLE;
                        t_d     = T_ZERO;
                    end else if (t_q == T_LAST) begin
                        state_d = ST_DATA;
                        t_d     = T_ZERO;
                        idx_d   = 3'd0;
                    end else begin
                        t_d = t_inc_s;
                    end
                end
                ST_DATA: begin
                    if (t_q == T_DEC) begin
                        shift_d[idx_q] = maj_s;
                    end else begin
                        shift_d = shift_q;
                    end
                    if (t_q == T_LAST) begin
                        t_d   = T_ZERO;
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        t_d = t_inc_s;
                    end
                end
                ST_PARITY: begin
                    if (t_q == T_DEC) begin
                        par_d = maj_s;
                    end else begin
                        par_d = par_q;
                    end
                    if (t_q == T_LAST) begin
                        state_d = ST_STOP;
                        t_d     = T_ZERO;
                    end else begin
                        t_d = t_inc_s;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit leaves room for a back-to-back start
                    if (t_q == T_DEC) begin
                        data_d  = shift_q;
                        perr_d  = (even_parity_bit(shift_q) != par_q);
                        ferr_d  = !maj_s;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                        t_d     = T_ZERO;
                    end else begin
                        t_d = t_inc_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    t_d     = T_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bluetooth_rx.sv
// Self-checking bench for bluetooth_rx: a tick-level frame model predicts
// every output each clk; literal frame lists pin both the model and the DUT.
`timescale 1ns/1ps
module tb_bluetooth_rx;
    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       rx = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, busy;

    bluetooth_rx dut (
        .clk(clk), .rst_in(rst_in), .rx(rx), .sample_tick(sample_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // line value seen by the receiver at each tick, and model predictions per tick
    bit         line_q[$];
    bit         done_a[];
    logic [7:0] dat_a[];
    bit         pe_a[], fe_a[], busy_a[];
    int         n_ticks = 0;
    int         n_frames = 0;
    int         cur_k = -1;
    bit         chk_en = 1'b0;
    logic [9:0] got_q[$];
    logic       ev = 1'b0, ep = 1'b0, ef = 1'b0;
    logic [7:0] ed = 8'h00;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mj(input int d, input int b);
        int i;
        i = d + 8 * b + 3;
        return (line_q[i] & line_q[i+1]) | (line_q[i] & line_q[i+2]) | (line_q[i+1] & line_q[i+2]);
    endfunction

    // Frame-level model: scan for 1->0 edges, vote each bit at its centre
    task automatic build_model();
        int k;
        int d;
        logic [7:0] by;
        bit prev;
        n_ticks = line_q.size();
        done_a = new[n_ticks]; dat_a = new[n_ticks];
        pe_a = new[n_ticks]; fe_a = new[n_ticks]; busy_a = new[n_ticks];
        for (int i = 0; i < n_ticks; i++) begin
            done_a[i] = 1'b0; dat_a[i] = 8'h00; pe_a[i] = 1'b0; fe_a[i] = 1'b0; busy_a[i] = 1'b0;
        end
        n_frames = 0;
        k = 0;
        while (k < n_ticks) begin
            prev = (k == 0) ? 1'b1 : line_q[k-1];
            if (prev && !line_q[k] && (k + 85 < n_ticks)) begin
                d = k;
                if (mj(d, 0)) begin
                    for (int j = d; j <= d + 4; j++) busy_a[j] = 1'b1;
                    k = d + 6;
                end else begin
                    for (int j = d; j <= d + 84; j++) busy_a[j] = 1'b1;
                    for (int b = 0; b < 8; b++) by[b] = mj(d, b + 1);
                    done_a[d+85] = 1'b1;
                    dat_a[d+85]  = by;
                    pe_a[d+85]   = ((^by) != mj(d, 9));
                    fe_a[d+85]   = !mj(d, 10);
                    n_frames++;
                    k = d + 86;
                end
            end else begin
                k++;
            end
        end
    endtask

    task automatic add_idle(input int n, input bit v);
        repeat (n) line_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] d, input bit p, input bit s, input int sw, input int pw);
        repeat (sw) line_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (8) line_q.push_back(d[b]);
        repeat (8) line_q.push_back(p);
        repeat (pw) line_q.push_back(s);
    endtask

    // One tick: present the line value, let the synchronizer settle, strobe once
    task automatic drive_tick(input bit v);
        rx = v;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic run_stream();
        build_model();
        cur_k = -1;
        ev = 1'b0; ed = 8'h00; ep = 1'b0; ef = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < line_q.size(); k++) drive_tick(line_q[k]);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
    endtask

    // Per-clk compare against the model
    initial begin
        logic tk;
        forever begin
            @(posedge clk);
            tk = sample_tick;
            #1;
            if (chk_en) begin
                if (tk) begin
                    cur_k++;
                    if (cur_k < n_ticks && done_a[cur_k]) begin
                        ev = 1'b1; ed = dat_a[cur_k]; ep = pe_a[cur_k]; ef = fe_a[cur_k];
                    end else begin
                        ev = 1'b0;
                    end
                end else begin
                    ev = 1'b0;
                end
                chk("rx_valid", {7'd0, rx_valid}, {7'd0, ev});
                chk("rx_data", rx_data, ed);
                chk("parity_err", {7'd0, parity_err}, {7'd0, ep});
                chk("frame_err", {7'd0, frame_err}, {7'd0, ef});
                chk("busy", {7'd0, busy},
                    {7'd0, (cur_k >= 0 && cur_k < n_ticks) ? busy_a[cur_k] : 1'b0});
                if (rx_valid) got_q.push_back({rx_data, parity_err, frame_err});
            end
        end
    end

    logic [9:0] exp_fr [10] = '{
        {8'hA5, 1'b0, 1'b0}, {8'h01, 1'b1, 1'b0}, {8'h01, 1'b0, 1'b0}, {8'h3C, 1'b0, 1'b1},
        {8'h55, 1'b0, 1'b0}, {8'hAA, 1'b0, 1'b0}, {8'h55, 1'b0, 1'b0}, {8'hAA, 1'b0, 1'b0},
        {8'h55, 1'b0, 1'b0}, {8'hAA, 1'b0, 1'b0}
    };

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset rx_data", rx_data, 8'h00);
        chk("reset rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("reset parity_err", {7'd0, parity_err}, 8'h00);
        chk("reset frame_err", {7'd0, frame_err}, 8'h00);
        chk("reset busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);

        add_idle(10, 1'b1);
        add_frame(8'hA5, 1'b0, 1'b1, 8, 8);  add_idle(5, 1'b1);
        add_frame(8'h01, 1'b0, 1'b1, 8, 8);  add_idle(5, 1'b1);
        add_frame(8'h01, 1'b1, 1'b1, 8, 8);  add_idle(5, 1'b1);
        add_idle(2, 1'b0);                   add_idle(14, 1'b1);
        add_frame(8'h3C, 1'b0, 1'b0, 8, 8);  add_idle(30, 1'b0); add_idle(10, 1'b1);
        add_frame(8'h55, 1'b0, 1'b1, 8, 8);  add_frame(8'hAA, 1'b0, 1'b1, 8, 8); add_idle(5, 1'b1);
        add_frame(8'h55, 1'b0, 1'b1, 7, 7);  add_frame(8'hAA, 1'b0, 1'b1, 9, 9); add_idle(5, 1'b1);
        add_frame(8'h55, 1'b0, 1'b1, 9, 9);  add_frame(8'hAA, 1'b0, 1'b1, 7, 7); add_idle(10, 1'b1);
        run_stream();

        chk("model frame count", 8'(n_frames), 8'd10);
        chk("dut frame count", 8'(got_q.size()), 8'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            chk("frame data", got_q[i][9:2], exp_fr[i][9:2]);
            chk("frame flags", {6'd0, got_q[i][1:0]}, {6'd0, exp_fr[i][1:0]});
        end

        // Reset in the middle of data bit 4 of an 0xFF frame
        got_q.delete();
        line_q.delete();
        add_idle(3, 1'b1);
        add_frame(8'hFF, 1'b0, 1'b1, 8, 8);
        for (int k = 0; k < 47; k++) drive_tick(line_q[k]);
        #1;
        chk("busy before reset", {7'd0, busy}, 8'd1);
        rst_in = 1'b0;
        #1;
        chk("mid-frame reset rx_data", rx_data, 8'h00);
        chk("mid-frame reset busy", {7'd0, busy}, 8'h00);
        chk("mid-frame reset rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("mid-frame reset flags", {6'd0, parity_err, frame_err}, 8'h00);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);

        line_q.delete();
        add_idle(5, 1'b1);
        add_frame(8'h12, 1'b0, 1'b1, 8, 8);
        add_idle(5, 1'b1);
        run_stream();
        chk("post-reset frame count", 8'(got_q.size()), 8'd1);
        if (got_q.size() > 0) chk("post-reset frame", got_q[0][9:2], 8'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
